// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction memory,
// and buffers {instr, pc} pairs in a small circular queue toward decode.
module fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter int          AW       = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] imem_a,
    input  logic [31:0]   imem_rd,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [31:0]   instr,
    output logic [31:0]   instr_pc,
    output logic [31:0]   instr_pc_plus4
);

    localparam int             IW      = $clog2(DEPTH);
    localparam int             PW      = IW + 1;
    localparam logic [PW-1:0]  DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0]  ONE_C   = PW'(1);

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] count_q, count_d;

    logic [31:0]   ent_instr_q [DEPTH];
    logic [31:0]   ent_pc_q    [DEPTH];

    logic             pop;
    logic             push;
    logic [DEPTH-1:0] wr_en;
    logic [IW-1:0]    rd_idx;
    logic [IW-1:0]    wr_idx;

    assign rd_idx = rd_ptr_q[IW-1:0];
    assign wr_idx = wr_ptr_q[IW-1:0];

    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid && instr_ready;
    // A full queue can still accept a word when the head leaves in the same cycle.
    assign push        = !redirect_valid && ((count_q < DEPTH_C) || pop);

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + ONE_C;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ONE_C;
            end
            count_d = count_q + PW'(push) - PW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
        assign wr_en[gi] = push && (wr_idx == IW'(gi));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_instr_q[i] <= '0;
                ent_pc_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    ent_instr_q[i] <= imem_rd;
                    ent_pc_q[i]    <= pc_q;
                end
            end
        end
    end

    assign imem_a         = pc_q[AW+1:2];
    assign instr          = ent_instr_q[rd_idx];
    assign instr_pc       = ent_pc_q[rd_idx];
    assign instr_pc_plus4 = instr_pc + 32'd4;

endmodule
